brightness_scheduler: RTL

BRIGHTNESS_SCHEDULER -- requirements
Module: brightness_scheduler

---
 rtl/brightness_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/brightness_scheduler.sv
// brightness_scheduler
// Sequences one frame of DEPTH-pixel blocks through a systolic array: takes a
// packed block from the loader, launches the array, waits (bounded by TIMEOUT)
// for the per-lane signed result, then writes each lane clamped to PIX_WIDTH
// unsigned into the pixel RAM at blk_idx*DEPTH + lane.
//
// Ports
//   clk, reset        clock (rising edge), synchronous active-high reset
//   start, num_blocks frame request; num_blocks sampled with start in IDLE/ERROR
//   ldr_valid/ldr_data/ldr_ready            loader handshake (ready = consumed)
//   arr_launch/arr_data                     array launch pulse and block copy
//   arr_result_valid/arr_result             array result, only looked at in WAIT_RES
//   wr_en/wr_addr/wr_data                   pixel RAM write port
//   busy, done, error                       status (error is sticky)
module brightness_scheduler #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned PE_DATA_WIDTH = 16,
  parameter int unsigned PIX_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH    = 6,
  parameter int unsigned TIMEOUT       = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [ADDR_WIDTH-2:0]            num_blocks,
  input  logic                             ldr_valid,
  input  logic [PE_DATA_WIDTH*DEPTH-1:0]   ldr_data,
  output logic                             ldr_ready,
  output logic                             arr_launch,
  output logic [PE_DATA_WIDTH*DEPTH-1:0]   arr_data,
  input  logic                             arr_result_valid,
  input  logic [PE_DATA_WIDTH*DEPTH-1:0]   arr_result,
  output logic                             wr_en,
  output logic [ADDR_WIDTH-1:0]            wr_addr,
  output logic [PIX_WIDTH-1:0]             wr_data,
  output logic                             busy,
  output logic                             done,
  output logic                             error
);

  localparam int unsigned LANE_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned NB_W   = ADDR_WIDTH - 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(DEPTH - 1);
  // The launch cycle counts toward the budget, so the last tolerated wait
  // cycle sees a count of TIMEOUT-2 and ERROR lands TIMEOUT cycles after launch.
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BLK, S_LAUNCH, S_WAIT_RES, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t                           r_state, w_next;
  logic [NB_W-1:0]                  r_num_blocks;
  logic [NB_W-1:0]                  r_blk_idx;
  logic [LANE_W-1:0]                r_lane;
  logic [TMO_W-1:0]                 r_tmo;
  logic [PE_DATA_WIDTH*DEPTH-1:0]   r_arr_data;
  logic [PE_DATA_WIDTH*DEPTH-1:0]   r_result;
  logic                             r_error;

  logic                             w_last_blk;
  logic [PE_DATA_WIDTH-1:0]         w_lane_val;
  logic [PIX_WIDTH-1:0]             w_pix;
  logic [ADDR_WIDTH-1:0]            w_addr;

  assign w_last_blk = (r_blk_idx + NB_W'(1)) == r_num_blocks;
  assign w_addr     = ADDR_WIDTH'(r_blk_idx) * ADDR_WIDTH'(DEPTH) + ADDR_WIDTH'(r_lane);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_ERROR: if (start) w_next = (num_blocks == '0) ? S_DONE : S_WAIT_BLK;
      S_WAIT_BLK:      if (ldr_valid) w_next = S_LAUNCH;
      S_LAUNCH:        w_next = S_WAIT_RES;
      S_WAIT_RES: begin
        if (arr_result_valid)     w_next = S_WRITE;
        else if (r_tmo == TMO_LAST) w_next = S_ERROR;
      end
      S_WRITE:         if (r_lane == LANE_LAST) w_next = w_last_blk ? S_DONE : S_WAIT_BLK;
      S_DONE:          w_next = S_IDLE;
      default:         w_next = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_num_blocks <= '0;
      r_blk_idx    <= '0;
      r_lane       <= '0;
      r_tmo        <= '0;
      r_arr_data   <= '0;
      r_result     <= '0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (start && (num_blocks != '0)) begin
            r_num_blocks <= num_blocks;
            r_blk_idx    <= '0;
            r_error      <= 1'b0;
          end
        end
        S_WAIT_BLK: if (ldr_valid) r_arr_data <= ldr_data;
        S_LAUNCH:   r_tmo <= '0;
        S_WAIT_RES: begin
          if (arr_result_valid) begin
            r_result <= arr_result;
            r_lane   <= '0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
            if (r_tmo == TMO_LAST) r_error <= 1'b1;
          end
        end
        S_WRITE: begin
          r_lane <= r_lane + 1'b1;
          if (r_lane == LANE_LAST) r_blk_idx <= r_blk_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Current lane of the registered result
  always_comb begin
    w_lane_val = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_lane == LANE_W'(i)) w_lane_val = r_result[i*PE_DATA_WIDTH +: PE_DATA_WIDTH];
    end
  end

  // Saturate signed lane value into the unsigned pixel range
  always_comb begin
    if (w_lane_val[PE_DATA_WIDTH-1])                   w_pix = '0;
    else if (|w_lane_val[PE_DATA_WIDTH-2:PIX_WIDTH])   w_pix = '1;
    else                                               w_pix = w_lane_val[PIX_WIDTH-1:0];
  end

  // Outputs
  always_comb begin
    ldr_ready  = 1'b0;
    arr_launch = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    done       = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_WAIT_BLK: ldr_ready  = ldr_valid;
      S_LAUNCH:   arr_launch = 1'b1;
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = w_addr;
        wr_data = w_pix;
      end
      S_DONE:     done = 1'b1;
      default: ;
    endcase
  end

  assign arr_data = r_arr_data;
  assign error    = r_error;

endmodule
